// File: rtl/cpu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | cpu_pkg: shared status codes, field bounds and fetch-unit types             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 12;

  localparam int OPCODE_HI    = 15;
  localparam int OPCODE_LO    = 12;
  localparam int ADDR_FIELD_HI = 11;
  localparam int ADDR_FIELD_LO = 0;

  localparam logic [7:0] ST_RESET_PC        = 8'h00;
  localparam logic [7:0] ST_FETCH           = 8'h01;
  localparam logic [7:0] ST_EXECUTE_LOAD    = 8'h02;
  localparam logic [7:0] ST_EXECUTE_STORE   = 8'h03;
  localparam logic [7:0] ST_EXECUTE_ALU     = 8'h04;
  localparam logic [7:0] ST_EXECUTE_BRANCH  = 8'h05;
  localparam logic [7:0] ST_DECODE          = 8'h10;
  localparam logic [7:0] ST_EXECUTE_HALT    = 8'h11;

  typedef enum logic [1:0] {
    IFU_RESET_PC = 2'd0,
    IFU_FETCH    = 2'd1,
    IFU_WAIT     = 2'd2,
    IFU_VALID    = 2'd3
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_ZERO = 2'd1,
    PC_INC  = 2'd2,
    PC_LOAD = 2'd3
  } pc_op_e;

  // FETCH and WAIT both report as "fetch"; VALID reports as "decode".
  function automatic logic [7:0] status_code(input ifu_state_e s);
    case (s)
      IFU_RESET_PC:        return ST_RESET_PC;
      IFU_FETCH, IFU_WAIT: return ST_FETCH;
      IFU_VALID:           return ST_DECODE;
      default:             return ST_RESET_PC;
    endcase
  endfunction

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | program_counter: clear / wrap-increment / branch-load PC register           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module program_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  pc_op_e                op,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_next
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Increment relies on natural truncation to wrap modulo 2^ADDR_WIDTH.
  always_comb begin
    pc_d = pc_q;
    case (op)
      PC_ZERO: pc_d = '0;
      PC_INC:  pc_d = pc_q + ADDR_WIDTH'(1);
      PC_LOAD: pc_d = target;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | instruction_fetch_unit: PC, program-memory read and instruction register    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] instruction_register,
  output logic                  ir_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  exec_done,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [7:0]            fetch_state
);

  localparam int              CW  = 3;
  localparam logic [CW-1:0]   LAT = CW'(MEM_LATENCY);

  ifu_state_e            state_q, state_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic [7:0]            fetch_state_q, fetch_state_d;
  pc_op_e                pc_op;
  logic [ADDR_WIDTH-1:0] pc_next;

  program_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_program_counter (
    .clock  (clock),
    .reset  (reset),
    .op     (pc_op),
    .target (branch_target),
    .pc     (pc),
    .pc_next(pc_next)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_op      = PC_HOLD;
    case (state_q)
      IFU_RESET_PC: begin
        pc_op   = PC_ZERO;
        state_d = IFU_FETCH;
      end
      IFU_FETCH: begin
        wait_cnt_d = LAT;
        state_d    = IFU_WAIT;
      end
      IFU_WAIT: begin
        // Counter value 1 marks the cycle in which mem_data is valid.
        if (wait_cnt_q <= CW'(1)) begin
          ir_d       = mem_data;
          ir_valid_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = IFU_VALID;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
      end
      IFU_VALID: begin
        if (exec_done) begin
          pc_op      = branch_taken ? PC_LOAD : PC_INC;
          ir_valid_d = 1'b0;
          state_d    = IFU_FETCH;
        end
      end
      default: begin
        ir_valid_d = 1'b0;
        state_d    = IFU_RESET_PC;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    mem_rd_d      = (state_d == IFU_FETCH);
    mem_addr_d    = (state_d == IFU_FETCH) ? pc_next : mem_addr_q;
    fetch_state_d = status_code(state_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IFU_RESET_PC;
      wait_cnt_q    <= '0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      ir_q          <= '0;
      ir_valid_q    <= 1'b0;
      fetch_state_q <= ST_RESET_PC;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      ir_q          <= ir_d;
      ir_valid_q    <= ir_valid_d;
      fetch_state_q <= fetch_state_d;
    end
  end

  assign mem_rd               = mem_rd_q;
  assign mem_addr             = mem_addr_q;
  assign instruction_register = ir_q;
  assign ir_valid             = ir_valid_q;
  assign fetch_state          = fetch_state_q;

endmodule
`default_nettype wire
